// File: rtl/vga_data_sequencer.sv
// vga_data_sequencer: drives the VGA data-select mux and the sec/min/hour VGA
// register load enables. In display mode it periodically reads the three RTC
// registers over the bus and loads each value into its VGA register. In edit
// mode it points the mux at RG1..RG3 so user edits show up live.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for the refresh interval to expire
//   REQ   | one cycle: read request issued for rd_addr, timeout counter loaded
//   WAIT  | rd_req held until rd_done or timeout expiry
//   LOAD  | one cycle: ld[idx] pulses (no pulse after a timeout), then advance
//   EDIT  | mux on RG1..RG3, all loads enabled every cycle
//
// A timed-out read also passes through LOAD (with no load enable) so rd_req
// always drops for at least one cycle between requests.
module vga_data_sequencer #(
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] ADDR_R0     = 8'h21,
  parameter logic [ADDR_W-1:0] ADDR_R1     = 8'h22,
  parameter logic [ADDR_W-1:0] ADDR_R2     = 8'h23,
  parameter int unsigned       REFRESH_CYC = 1_000_000,
  parameter int unsigned       TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              edit_mode,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              seleccion,
  output logic              ld1,
  output logic              ld2,
  output logic              ld3,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned REF_W = $clog2(REFRESH_CYC);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRESH_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_EDIT
  } state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [REF_W-1:0] refresh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             scan_tmo;
  logic [2:0]       ld_q;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] i);
    case (i)
      2'd0:    addr_of = ADDR_R0;
      2'd1:    addr_of = ADDR_R1;
      default: addr_of = ADDR_R2;
    endcase
  endfunction

  function automatic logic [2:0] ld_of(input logic [1:0] i);
    ld_of = 3'b001 << i;
  endfunction

  assign ld1 = ld_q[0];
  assign ld2 = ld_q[1];
  assign ld3 = ld_q[2];

  // Sequencer FSM; every output is a register updated on the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      refresh_cnt <= REF_LOAD;
      tmo_cnt     <= '0;
      scan_tmo    <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= ADDR_R0;
      seleccion   <= 1'b0;
      ld_q        <= 3'b000;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (edit_mode) begin
            state     <= S_EDIT;
            seleccion <= 1'b1;
            ld_q      <= 3'b111;
          end else if (refresh_cnt == '0) begin
            state    <= S_REQ;
            idx      <= 2'd0;
            rd_req   <= 1'b1;
            rd_addr  <= ADDR_R0;
            busy     <= 1'b1;
            scan_tmo <= 1'b0;
          end else begin
            refresh_cnt <= refresh_cnt - 1'b1;
          end
        end

        S_REQ: begin
          state   <= S_WAIT;
          tmo_cnt <= TMO_LOAD;
        end

        S_WAIT: begin
          // rd_done wins over a timeout expiring in the same cycle
          if (rd_done) begin
            state  <= S_LOAD;
            rd_req <= 1'b0;
            ld_q   <= ld_of(idx);
          end else if (tmo_cnt == '0) begin
            state       <= S_LOAD;
            rd_req      <= 1'b0;
            timeout_err <= 1'b1;
            scan_tmo    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end

        S_LOAD: begin
          ld_q <= 3'b000;
          if (idx == 2'd2 && !scan_tmo) begin
            timeout_err <= 1'b0;
          end
          if (edit_mode) begin
            // remainder of the scan is dropped; next scan restarts at idx 0
            state     <= S_EDIT;
            idx       <= 2'd0;
            busy      <= 1'b0;
            seleccion <= 1'b1;
            ld_q      <= 3'b111;
            if (idx == 2'd2) begin
              refresh_cnt <= REF_LOAD;
            end
          end else if (idx == 2'd2) begin
            state       <= S_IDLE;
            idx         <= 2'd0;
            busy        <= 1'b0;
            refresh_cnt <= REF_LOAD;
          end else begin
            state   <= S_REQ;
            idx     <= idx + 2'd1;
            rd_req  <= 1'b1;
            rd_addr <= addr_of(idx + 2'd1);
          end
        end

        S_EDIT: begin
          if (!edit_mode) begin
            // zero count so a fresh scan starts right after leaving edit
            state       <= S_IDLE;
            refresh_cnt <= '0;
            seleccion   <= 1'b0;
            ld_q        <= 3'b000;
          end else begin
            ld_q <= 3'b111;
          end
        end

        default: begin
          state  <= S_IDLE;
          rd_req <= 1'b0;
          ld_q   <= 3'b000;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_data_sequencer.sv
// Testbench for vga_data_sequencer: a cycle table for reset, edit-mode and
// timeout sequences, randomized display scans checked against a duration-based
// scan model, and an asynchronous reset in the middle of a bus read.
module tb_vga_data_sequencer;

  localparam int R = 8;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       edit_mode = 1'b0;
  logic       rd_done = 1'b0;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       seleccion, ld1, ld2, ld3, busy, timeout_err;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] addr_tab [3];

  typedef struct {
    logic       edit;
    logic       done;
    logic       req;
    logic [7:0] addr;
    logic [2:0] ld;
    logic       sel;
    logic       bsy;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  vga_data_sequencer #(
    .ADDR_W     (8),
    .ADDR_R0    (8'h21),
    .ADDR_R1    (8'h22),
    .ADDR_R2    (8'h23),
    .REFRESH_CYC(R),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .edit_mode  (edit_mode),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_done    (rd_done),
    .seleccion  (seleccion),
    .ld1        (ld1),
    .ld2        (ld2),
    .ld3        (ld3),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // observed output vector: {rd_req, rd_addr, ld3, ld2, ld1, seleccion, busy, timeout_err}
  function automatic logic [14:0] obs();
    return {rd_req, rd_addr, ld3, ld2, ld1, seleccion, busy, timeout_err};
  endfunction

  function automatic logic [14:0] mk(input logic req, input logic [7:0] addr,
                                     input logic [2:0] ld, input logic sel,
                                     input logic bsy, input logic err);
    return {req, addr, ld, sel, bsy, err};
  endfunction

  function automatic vec_t row(input logic edit, input logic done, input logic req,
                               input logic [7:0] addr, input logic [2:0] ld,
                               input logic sel, input logic bsy, input logic err);
    vec_t v;
    v.edit = edit; v.done = done; v.req = req; v.addr = addr;
    v.ld = ld; v.sel = sel; v.bsy = bsy; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scan model: each read is REQ + min(d,T) WAIT cycles + one LOAD cycle, where
  // d is the WAIT cycle carrying rd_done (d > T means no reply). A scan is three
  // reads followed by R idle cycles. timeout_err rises in the LOAD cycle of a
  // timed-out read and falls after a scan without any timeout.
  task automatic random_scans(input int n_scans, input logic err_start);
    logic       err_now;
    logic       scan_to;
    logic [2:0] ld_exp;
    int         d, wc, waited;
    err_now = err_start;
    rd_done = 1'b0;
    edit_mode = 1'b0;
    waited = 0;
    while (rd_req !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check("rand_sync", obs(), mk(1'b1, addr_tab[0], 3'b000, 1'b0, 1'b1, err_now));
    for (int s = 0; s < n_scans; s++) begin
      scan_to = 1'b0;
      for (int i = 0; i < 3; i++) begin
        d = (s == 0) ? int'($urandom_range(1, T)) : int'($urandom_range(1, T + 1));
        wc = (d <= T) ? d : T;
        if (!(s == 0 && i == 0)) tick();
        check("rand_req", obs(), mk(1'b1, addr_tab[i], 3'b000, 1'b0, 1'b1, err_now));
        rd_done = 1'b0;
        for (int j = 1; j <= wc; j++) begin
          tick();
          check("rand_wait", obs(), mk(1'b1, addr_tab[i], 3'b000, 1'b0, 1'b1, err_now));
          rd_done = (j == d);
        end
        if (d > T) begin
          scan_to = 1'b1;
          err_now = 1'b1;
        end
        tick();
        rd_done = 1'b0;
        ld_exp = (d <= T) ? 3'(1 << i) : 3'b000;
        check("rand_load", obs(), mk(1'b0, addr_tab[i], ld_exp, 1'b0, 1'b1, err_now));
      end
      if (!scan_to) err_now = 1'b0;
      for (int k = 0; k < R; k++) begin
        tick();
        check("rand_idle", obs(), mk(1'b0, addr_tab[2], 3'b000, 1'b0, 1'b0, err_now));
        rd_done = ($urandom_range(0, 3) == 0);
      end
    end
    rd_done = 1'b0;
  endtask

  initial begin
    int waited;
    addr_tab[0] = 8'h21;
    addr_tab[1] = 8'h22;
    addr_tab[2] = 8'h23;

    // edit, done | req, addr, ld{3,2,1}, sel, busy, err  (outputs after the edge)
    tbl.push_back(row(0, 0, 0, 8'h21, 3'b000, 0, 0, 0)); // idle countdown
    tbl.push_back(row(0, 1, 0, 8'h21, 3'b000, 0, 0, 0)); // stray rd_done in IDLE
    tbl.push_back(row(1, 0, 0, 8'h21, 3'b111, 1, 0, 0)); // enter EDIT
    tbl.push_back(row(1, 1, 0, 8'h21, 3'b111, 1, 0, 0)); // stray rd_done in EDIT
    tbl.push_back(row(1, 0, 0, 8'h21, 3'b111, 1, 0, 0));
    tbl.push_back(row(0, 0, 0, 8'h21, 3'b000, 0, 0, 0)); // leave EDIT
    tbl.push_back(row(0, 0, 1, 8'h21, 3'b000, 0, 1, 0)); // REQ 21 right away
    tbl.push_back(row(0, 0, 1, 8'h21, 3'b000, 0, 1, 0)); // WAIT1
    tbl.push_back(row(0, 1, 0, 8'h21, 3'b001, 0, 1, 0)); // LOAD ld1
    tbl.push_back(row(0, 0, 1, 8'h22, 3'b000, 0, 1, 0)); // REQ 22
    tbl.push_back(row(0, 0, 1, 8'h22, 3'b000, 0, 1, 0)); // WAIT1
    tbl.push_back(row(1, 0, 1, 8'h22, 3'b000, 0, 1, 0)); // edit during WAIT: held
    tbl.push_back(row(1, 0, 1, 8'h22, 3'b000, 0, 1, 0));
    tbl.push_back(row(1, 1, 0, 8'h22, 3'b010, 0, 1, 0)); // ld2 once
    tbl.push_back(row(1, 0, 0, 8'h22, 3'b111, 1, 0, 0)); // EDIT, no addr 23
    tbl.push_back(row(1, 0, 0, 8'h22, 3'b111, 1, 0, 0));
    tbl.push_back(row(0, 0, 0, 8'h22, 3'b000, 0, 0, 0)); // leave EDIT
    tbl.push_back(row(0, 0, 1, 8'h21, 3'b000, 0, 1, 0)); // REQ 21
    tbl.push_back(row(0, 0, 1, 8'h21, 3'b000, 0, 1, 0)); // WAIT1..4, no reply
    tbl.push_back(row(0, 0, 1, 8'h21, 3'b000, 0, 1, 0));
    tbl.push_back(row(0, 0, 1, 8'h21, 3'b000, 0, 1, 0));
    tbl.push_back(row(0, 0, 1, 8'h21, 3'b000, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 8'h21, 3'b000, 0, 1, 1)); // timeout: no ld1, err set
    tbl.push_back(row(0, 0, 1, 8'h22, 3'b000, 0, 1, 1)); // REQ 22 next
    tbl.push_back(row(0, 0, 1, 8'h22, 3'b000, 0, 1, 1));
    tbl.push_back(row(0, 1, 0, 8'h22, 3'b010, 0, 1, 1));
    tbl.push_back(row(0, 0, 1, 8'h23, 3'b000, 0, 1, 1));
    tbl.push_back(row(0, 0, 1, 8'h23, 3'b000, 0, 1, 1));
    tbl.push_back(row(0, 1, 0, 8'h23, 3'b100, 0, 1, 1));
    tbl.push_back(row(0, 0, 0, 8'h23, 3'b000, 0, 0, 1)); // IDLE, err kept

    // asynchronous reset values
    #2 rst_n = 1'b0;
    #1 check("reset_async", obs(), mk(1'b0, 8'h21, 3'b000, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1 check("reset_hold", obs(), mk(1'b0, 8'h21, 3'b000, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      edit_mode = tbl[k].edit;
      rd_done   = tbl[k].done;
      tick();
      check($sformatf("table_row%0d", k), obs(),
            mk(tbl[k].req, tbl[k].addr, tbl[k].ld, tbl[k].sel, tbl[k].bsy, tbl[k].err));
    end
    edit_mode = 1'b0;
    rd_done = 1'b0;

    // first random scan is clean, so the sticky error from the table clears
    random_scans(6, 1'b1);

    // reset in the middle of WAIT
    waited = 0;
    while (rd_req !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    tick();
    tick();
    check("pre_reset_wait", {14'd0, rd_req}, 15'd1);
    #3 rst_n = 1'b0;
    #1 check("reset_mid_wait", obs(), mk(1'b0, 8'h21, 3'b000, 1'b0, 1'b0, 1'b0));
    tick();
    check("reset_mid_hold", obs(), mk(1'b0, 8'h21, 3'b000, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (rd_req !== 1'b1 && waited < 30);
    check("post_reset_delay", 15'(waited), 15'(R));
    check("post_reset_req", obs(), mk(1'b1, 8'h21, 3'b000, 1'b0, 1'b1, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
